// File: rtl/sparc_pipe_pkg.sv
// Shared pipeline definitions for the SPARC front end.
//   PC_STEP       : byte increment per sequential fetch
//   NOP_WORD      : sethi 0,%g0, substituted for annulled/bubble slots
//   fetch_state_e : fetch-unit sequencing states
//   redirect_t    : captured control-transfer request from ID
package sparc_pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] PC_STEP  = 32'd4;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0100_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic            taken;
    logic            annul;
    logic [XLEN-1:0] target;
  } redirect_t;

endpackage

// File: rtl/sparc_pc_npc_reg.sv
// SPARC PC/nPC register pair.
//   clk, clr (async active-low)  : clock / reset
//   load                         : advance the pair this cycle (else hold)
//   redirect, target             : on load, jump to target instead of nPC
//   pc, npc                      : current fetch PC and next PC
module sparc_pc_npc_reg
  import sparc_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            load,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] npc
);

  // Sequential fetch and redirect both wrap silently modulo 2^32.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc  <= RESET_PC;
      npc <= RESET_PC + PC_STEP;
    end else if (load) begin
      if (redirect) begin
        pc  <= target;
        npc <= target + PC_STEP;
      end else begin
        pc  <= npc;
        npc <= npc + PC_STEP;
      end
    end
  end

endmodule

// File: rtl/sparc_fetch_pc_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Owns PC/nPC, applies ID's delayed-branch redirects and delay-slot
// annulment, and holds a redirect requested during a stall until LE returns.
//   clk, clr (async active-low)            : clock / reset
//   LE                                     : pipeline load enable (0 = stall)
//   branch_taken, branch_target            : taken control transfer from ID
//   annul_slot                             : annul the slot being fetched
//   imem_data / imem_addr                  : combinational instruction memory
//   PC_IF_out, nPC_IF_out                  : PC and nPC toward IF/ID
//   instruction_out, fetch_valid           : fetched word (NOP when invalid)
//   IF_ID_LE, IF_ID_reset                  : IF/ID load enable and sync flush
// Optional build macro FETCH_MISALIGN_TRAP_EN adds misalign_trap: a redirect
// to a non-word-aligned target is forced to the word boundary, the forced
// fetch is marked invalid, and the sticky trap flag is raised until clr.
module sparc_fetch_pc_unit
  import sparc_pipe_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            LE,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            annul_slot,
  input  logic [XLEN-1:0] imem_data,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] PC_IF_out,
  output logic [XLEN-1:0] nPC_IF_out,
  output logic [XLEN-1:0] instruction_out,
  output logic            IF_ID_LE,
  output logic            IF_ID_reset,
  output logic            fetch_valid
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic            misalign_trap
`endif
);

  fetch_state_e    state_q, state_d;
  redirect_t       pend_q, pend_d;
  redirect_t       req_c;
  logic            advance_c;
  logic [XLEN-1:0] target_c;
  logic            forced_c;
  logic [XLEN-1:0] pc, npc;

  // In PEND the live ID inputs are stale repeats; use the captured request.
  always_comb begin
    req_c.taken  = branch_taken;
    req_c.annul  = annul_slot;
    req_c.target = branch_target;
    if (state_q == PEND) begin
      req_c = pend_q;
    end
  end

  assign advance_c = LE && (state_q != BOOT);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_c;
  logic forced_q;

  assign misaligned_c = req_c.taken && (req_c.target[1:0] != 2'b00);
  assign target_c     = {req_c.target[XLEN-1:2], 2'b00};
  assign forced_c     = forced_q;

  // forced_q marks the fetch at a forced-aligned address; it persists
  // across stalls until that slot is consumed.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      forced_q      <= 1'b0;
      misalign_trap <= 1'b0;
    end else if (advance_c) begin
      forced_q <= misaligned_c;
      if (misaligned_c) begin
        misalign_trap <= 1'b1;
      end
    end
  end
`else
  assign target_c = req_c.target;
  assign forced_c = 1'b0;
`endif

  sparc_pc_npc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_npc (
    .clk      (clk),
    .clr      (clr),
    .load     (advance_c),
    .redirect (req_c.taken),
    .target   (target_c),
    .pc       (pc),
    .npc      (npc)
  );

  assign imem_addr  = pc;
  assign PC_IF_out  = pc;
  assign nPC_IF_out = npc;

  // State and pending-request registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= BOOT;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state and IF/ID-facing outputs. Whenever IF/ID does not load, a
  // NOP with fetch_valid=0 is presented since nothing is being delivered.
  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    fetch_valid     = 1'b0;
    instruction_out = NOP_WORD;
    IF_ID_LE        = 1'b0;
    IF_ID_reset     = 1'b0;

    unique case (state_q)
      BOOT: begin
        IF_ID_reset = 1'b1;
        state_d     = RUN;
      end
      RUN: begin
        if (!LE && (branch_taken || annul_slot)) begin
          pend_d.taken  = branch_taken;
          pend_d.annul  = annul_slot;
          pend_d.target = branch_target;
          state_d       = PEND;
        end
      end
      PEND: begin
        if (LE) begin
          pend_d  = '0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase

    if (advance_c) begin
      IF_ID_LE = 1'b1;
      if (req_c.annul || forced_c) begin
        IF_ID_reset = 1'b1;
      end else begin
        fetch_valid     = 1'b1;
        instruction_out = imem_data;
      end
    end
  end

endmodule

// File: tb/tb_sparc_fetch_pc_unit.sv
// Self-checking bench for sparc_fetch_pc_unit: directed test-plan sequences
// with literal expectations, then randomized stimulus against a
// behavioural PC/nPC model.
module tb_sparc_fetch_pc_unit;
  import sparc_pipe_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clr;
  logic        LE;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        annul_slot;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] PC_IF_out;
  logic [31:0] nPC_IF_out;
  logic [31:0] instruction_out;
  logic        IF_ID_LE;
  logic        IF_ID_reset;
  logic        fetch_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Model of architectural fetch state.
  logic [31:0] m_pc, m_npc, m_ptgt;
  logic        m_boot, m_pend, m_pt, m_pa, m_forced, m_trap;

  // Values the DUT presented during the most recent step (pre-edge).
  logic [31:0] s_ins;
  logic        s_fv, s_rst, s_le;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C3C_0000;
  endfunction

  assign imem_data = mem_word(imem_addr);

  sparc_fetch_pc_unit #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .clr             (clr),
    .LE              (LE),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .annul_slot      (annul_slot),
    .imem_data       (imem_data),
    .imem_addr       (imem_addr),
    .PC_IF_out       (PC_IF_out),
    .nPC_IF_out      (nPC_IF_out),
    .instruction_out (instruction_out),
    .IF_ID_LE        (IF_ID_LE),
    .IF_ID_reset     (IF_ID_reset),
    .fetch_valid     (fetch_valid)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .misalign_trap   (misalign_trap)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for the current cycle, from the model and live inputs.
  task automatic compare_now();
    logic [31:0] e_ins;
    logic        e_fv, e_rst, e_le, ann;
    e_ins = NOP_WORD; e_fv = 1'b0; e_rst = 1'b0; e_le = 1'b0;
    if (m_boot) begin
      e_rst = 1'b1;
    end else if (LE) begin
      e_le = 1'b1;
      ann  = m_pend ? m_pa : annul_slot;
      if (ann || m_forced) begin
        e_rst = 1'b1;
      end else begin
        e_fv  = 1'b1;
        e_ins = mem_word(m_pc);
      end
    end
    chk("imem_addr", imem_addr, m_pc);
    chk("PC_IF_out", PC_IF_out, m_pc);
    chk("nPC_IF_out", nPC_IF_out, m_npc);
    chk("instruction_out", instruction_out, e_ins);
    chk("fetch_valid", 32'(fetch_valid), 32'(e_fv));
    chk("IF_ID_LE", 32'(IF_ID_LE), 32'(e_le));
    chk("IF_ID_reset", 32'(IF_ID_reset), 32'(e_rst));
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("misalign_trap", 32'(misalign_trap), 32'(m_trap));
`endif
    s_ins = instruction_out; s_fv = fetch_valid; s_rst = IF_ID_reset; s_le = IF_ID_LE;
  endtask

  // Model update for a rising edge with clr high.
  task automatic model_edge();
    logic        t;
    logic [31:0] g;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (!LE) begin
      if (!m_pend && (branch_taken || annul_slot)) begin
        m_pend = 1'b1; m_pt = branch_taken; m_pa = annul_slot; m_ptgt = branch_target;
      end
    end else begin
      t = m_pend ? m_pt : branch_taken;
      g = m_pend ? m_ptgt : branch_target;
      m_pend = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      m_forced = t && (g % 4 != 0);
      if (m_forced) m_trap = 1'b1;
      g = g - (g % 4);
`endif
      if (t) begin
        m_pc = g; m_npc = g + 4;
      end else begin
        m_pc = m_npc; m_npc = m_npc + 4;
      end
    end
  endtask

  // One cycle: starts and ends at a falling edge.
  task automatic step(input logic le, input logic bt, input logic [31:0] tg, input logic an);
    LE = le; branch_taken = bt; branch_target = tg; annul_slot = an;
    #1;
    compare_now();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Asserts clr for one cycle starting at a falling edge.
  task automatic do_reset();
    clr = 1'b0;
    #1;
    m_pc = RST_PC; m_npc = RST_PC + 4; m_boot = 1'b1; m_pend = 1'b0;
    m_pt = 1'b0; m_pa = 1'b0; m_ptgt = '0; m_forced = 1'b0; m_trap = 1'b0;
    compare_now();
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    logic [31:0] tg;
    clr = 1'b0; LE = 1'b0; branch_taken = 1'b0; branch_target = '0; annul_slot = 1'b0;
    @(negedge clk);
    do_reset();

    // Boot and sequential fetch.
    step(1, 0, 0, 0);
    chk("boot_fetch_valid", 32'(s_fv), 32'd0);
    chk("boot_hold_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0); chk("seq_addr_4", imem_addr, 32'h4);
    chk("run_IF_ID_LE", 32'(s_le), 32'd1);
    step(1, 0, 0, 0); chk("seq_addr_8", imem_addr, 32'h8);
    step(1, 0, 0, 0); chk("seq_addr_c", imem_addr, 32'hC);
    step(1, 0, 0, 0); chk("seq_addr_10", imem_addr, 32'h10);

    // Taken branch, delay slot passed.
    step(1, 1, 32'h100, 0);
    chk("slot_valid", 32'(s_fv), 32'd1);
    chk("slot_word", s_ins, 32'h3C2C_FFFF);
    chk("br_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0); chk("br_seq", imem_addr, 32'h104);

    // Taken branch, delay slot annulled.
    step(1, 1, 32'h100, 1);
    chk("annul_nop", s_ins, 32'h0100_0000);
    chk("annul_flush", 32'(s_rst), 32'd1);
    chk("annul_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0);
    chk("post_annul_flush", 32'(s_rst), 32'd0);

    // Redirect captured during a stall, applied once.
    step(0, 1, 32'h200, 0); chk("stall_addr", imem_addr, 32'h104);
    step(0, 1, 32'h200, 0);
    step(0, 1, 32'h200, 0); chk("stall_addr3", imem_addr, 32'h104);
    step(1, 1, 32'h200, 0); chk("pend_apply", imem_addr, 32'h200);
    step(1, 0, 0, 0); chk("pend_once", imem_addr, 32'h204);

    // Reset during PEND discards the pending redirect.
    step(0, 1, 32'h300, 0);
    step(0, 1, 32'h300, 0);
    do_reset();
    chk("rst_addr", imem_addr, RST_PC);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0); chk("rst_no_pend", imem_addr, 32'h4);

    // Wrap-around of PC/nPC.
    step(1, 1, 32'hFFFF_FFF8, 0);
    step(1, 0, 0, 0);
    chk("wrap_pc_fc", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_npc_0", nPC_IF_out, 32'h0);
    step(1, 0, 0, 0);
    chk("wrap_pc_0", imem_addr, 32'h0);
    chk("wrap_npc_4", nPC_IF_out, 32'h4);

`ifdef FETCH_MISALIGN_TRAP_EN
    step(1, 1, 32'h102, 0);
    chk("mis_addr", imem_addr, 32'h100);
    chk("mis_trap", 32'(misalign_trap), 32'd1);
    step(1, 0, 0, 0);
    chk("mis_forced_invalid", 32'(s_fv), 32'd0);
    step(1, 0, 0, 0);
    chk("mis_trap_sticky", 32'(misalign_trap), 32'd1);
    chk("mis_after_valid", 32'(s_fv), 32'd1);
`else
    step(1, 1, 32'h102, 0);
    chk("target_verbatim", imem_addr, 32'h102);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset();
      end else begin
        tg = $urandom();
        if ($urandom_range(3) != 0) tg[1:0] = 2'b00;
        step(logic'($urandom_range(9) < 7), logic'($urandom_range(4) == 0),
             tg, logic'($urandom_range(6) == 0));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparc_fetch_pc_unit.md
Name: sparc_fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the SPARC PC/nPC pair and drives the instruction-memory address.
- Applies delayed-branch redirects and delay-slot annulment requested by ID.
- Drives the IF/ID register's PC, instruction, load-enable and synchronous-flush inputs; holds a pending redirect across stalls.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset; nPC resets to RESET_PC+PC_STEP
PC_STEP, 4, byte increment per sequential fetch
NOP_WORD, 32'h0100_0000, instruction substituted for an annulled or bubble slot (sethi 0,%g0)

Ports:
clk  in  1  clock, rising-edge active
clr  in  1  asynchronous active-low reset (one clock; reset is asynchronous and active-low)
LE  in  1  pipeline load enable from hazard unit; 0 = stall (hold PC/nPC)
branch_taken  in  1  ID-stage control-transfer taken this cycle
branch_target  in  32  byte target of taken transfer
annul_slot  in  1  ID requests annulment of the delay slot currently being fetched
imem_data  in  32  instruction word read at imem_addr (combinational memory)
imem_addr  out  32  current PC
PC_IF_out  out  32  PC to IF/ID
nPC_IF_out  out  32  nPC (debug/trap use)
instruction_out  out  32  imem_data, or NOP_WORD when slot is invalid/annulled
IF_ID_LE  out  1  load enable to IF/ID
IF_ID_reset  out  1  synchronous flush to IF/ID (active high)
fetch_valid  out  1  instruction_out carries a real instruction

Behaviour:
- Reset (clr=0, async): PC=RESET_PC, nPC=RESET_PC+4, state=BOOT, pending regs cleared. Outputs during reset: imem_addr=RESET_PC, fetch_valid=0, instruction_out=NOP_WORD, IF_ID_LE=0, IF_ID_reset=1.
- States: BOOT, RUN, PEND.
  - BOOT: one cycle after clr deasserts; fetch_valid=0, IF_ID_reset=1; PC/nPC unchanged; -> RUN unconditionally.
  - RUN, LE=1, no redirect: PC<=nPC, nPC<=nPC+4 (mod 2^32, wrap silently). fetch_valid=1, IF_ID_LE=1.
  - RUN, LE=1, branch_taken=1: PC<=branch_target, nPC<=branch_target+4. The instruction now at PC is the delay slot and passes to IF/ID unless annul_slot=1.
  - annul_slot=1 with LE=1 (taken or not): instruction_out=NOP_WORD, fetch_valid=0, IF_ID_reset=1 for that cycle. Not taken: PC<=nPC, nPC<=nPC+4.
  - RUN, LE=0: PC/nPC hold, IF_ID_LE=0, IF_ID_reset=0. If branch_taken or annul_slot are asserted, latch target/taken/annul into pending regs and go to PEND.
  - PEND: hold while LE=0 and ignore new branch_taken/annul_slot inputs (ID is frozen, so they repeat). On first LE=1, apply the pending redirect/annul exactly as RUN would, then clear pending and go to RUN.
- Latency: redirect takes effect on imem_addr one cycle after the sampled edge; zero-bubble for delay slot.
- Simultaneous LE=0 and branch_taken in PEND: no double capture.
- clr asserted mid-PEND discards the pending redirect.
- branch_target is used verbatim except where the optional feature applies.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Enabled:
  - Adds output misalign_trap (1 bit, sticky until clr).
  - A redirect with branch_target[1:0]!=0 sets misalign_trap the following cycle and loads PC with target[31:2],2'b00.
  - The fetch at the forced address has fetch_valid=0.
- Disabled: port absent; target used unmodified; no check.

Decomposition:
- Shared package sparc_pipe_pkg holds:
  - fetch state enum {BOOT, RUN, PEND}
  - NOP_WORD constant
  - PC_STEP constant
- One sub-module is natural: sparc_pc_npc_reg, the PC/nPC pair with load/hold/redirect muxing.
- The FSM, pending registers and output muxing stay in the top.

Test Plan:
- Reset release, RESET_PC=0, LE=1 for 4 cycles -> BOOT cycle fetch_valid=0; then imem_addr 0,4,8,12; IF_ID_LE=1.
- At PC=0x10, branch_taken=1, target=0x100, annul_slot=0 -> delay slot 0x10 passed valid; next imem_addr=0x100, then 0x104.
- Same branch with annul_slot=1 -> instruction_out=0x01000000, IF_ID_reset=1 for one cycle; next addr 0x100.
- LE=0 for 3 cycles with branch_taken=1, target=0x200 captured in the first -> addr frozen, state PEND; on LE=1 addr becomes 0x200 exactly once.
- clr pulsed low during PEND -> addr returns to RESET_PC, pending target 0x200 never applied.
- nPC=0xFFFF_FFFC sequential -> PC wraps to 0x0000_0000, nPC=0x4. With FETCH_MISALIGN_TRAP_EN, target=0x102 -> PC=0x100, misalign_trap=1 until clr.
